// File: rtl/lfsr_stream_decrypt.sv
// LFSR stream decrypter: XORs ciphertext with an 8-bit Fibonacci LFSR keystream kept in
// lockstep with the matching encrypter, with per-frame rekey and a saturating byte count.
`timescale 1ns/1ps
module lfsr_stream_decrypt #(
  parameter logic [7:0]  SEED_DEFAULT = 8'h41,
  parameter int unsigned FRAME_LEN    = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [7:0]       i_seed,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [7:0]       o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_byte_count
);

  localparam int unsigned FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = (FRAME_LEN == 0) ? '0 : FC_W'(FRAME_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_lfsr;
  logic [7:0]       r_seed_reg;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_byte_count;
  logic [FC_W-1:0]  r_frame_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_frame_end;
  logic [7:0]       w_lfsr_next;
  logic [7:0]       w_seed_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // stop has priority over start; start while running is a restart
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    if (i_stop) begin
      w_state_next = ST_IDLE;
    end else if (i_start) begin
      w_state_next = ST_RUN;
    end
    if ((r_state == ST_RUN) && !i_start && !i_stop && (!r_out_valid || i_out_ready)) begin
      w_in_ready = 1'b1;
    end
  end

  assign w_accept    = i_in_valid && w_in_ready;
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[0] ^ r_lfsr[5] ^ r_lfsr[6] ^ r_lfsr[7]};
  assign w_seed_sel  = (i_seed == 8'h00) ? SEED_DEFAULT : i_seed;
  assign w_frame_end = (FRAME_LEN != 0) && (r_frame_cnt == FRAME_LAST);

  // The last byte of a frame still uses the running key; the reload replaces the step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed_reg   <= SEED_DEFAULT;
      r_lfsr       <= SEED_DEFAULT;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_start) begin
        r_seed_reg  <= w_seed_sel;
        r_lfsr      <= w_seed_sel;
        r_frame_cnt <= '0;
      end else if (w_accept) begin
        if (w_frame_end) begin
          r_lfsr       <= r_seed_reg;
          r_frame_cnt  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_lfsr      <= w_lfsr_next;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_count <= '0;
    end else if (i_start) begin
      r_byte_count <= '0;
    end else if (w_accept && !(&r_byte_count)) begin
      r_byte_count <= r_byte_count + 1'b1;
    end
  end

  // A restart does not flush the output register, so a pending byte still drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= i_in_data ^ r_lfsr;
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = (r_state == ST_RUN);
  assign o_frame_done = r_frame_done;
  assign o_byte_count = r_byte_count;

endmodule
